carregador_instrucoes: RTL
==========================

// Module: carregador_instrucoes
// PURPOSE
//   Write side of the instruction memory: a boot loader that accepts the program as a byte stream
//   (valid/ready), assembles big-endian 32-bit instruction words and writes them sequentially into
//   the instruction store through a single-cycle write port. Loading stops after the word whose
//   opcode is HALT, or with an error if the address window fills first. Sits between the host/serial
//   front end and the instruction memory; the CPU is held off until concluido=1.
// PARAMETERS
//   BASE_ADDR    1      first word address written (index 0 is never loaded)
//   LAST_ADDR    150    last valid word address of the instruction store
//   HALT_OPCODE  5'd18  opcode in bits [31:27] that terminates the program
// PORTS
//   clock       in   1   single clock, all state on rising edge
//   reset       in   1   asynchronous, active-low reset
//   iniciar     in   1   one-cycle pulse: arm a new load
//   byte_valid  in   1   byte_dado valid
//   byte_dado   in   8   program byte, most-significant byte of each word first
//   byte_ready  out  1   loader accepts a byte this cycle
//   mem_we      out  1   write strobe to instruction memory, one cycle per word
//   mem_addr    out  32  word address for the write
//   mem_wdata   out  32  instruction word
//   palavras    out  8   number of words written in the current/last load
//   concluido   out  1   load finished with HALT written (level)
//   erro        out  1   window full without HALT (level)
// BEHAVIOUR
//   - Reset (reset=0, any time, async): state OCIOSO; byte_ready, mem_we, concluido, erro = 0;
//     mem_addr, mem_wdata, palavras, byte counter, word shift register = 0. Partial word discarded.
//   - States: OCIOSO, RECEBENDO, ESCREVENDO, CONCLUIDO, ERRO.
//   - OCIOSO/CONCLUIDO/ERRO + iniciar=1 -> RECEBENDO; next cycle: addr=BASE_ADDR, byte count=0,
//     palavras=0, concluido=erro=0. iniciar in RECEBENDO or ESCREVENDO is ignored.
//   - RECEBENDO: byte_ready=1 (registered, high the whole state). Transfer = byte_valid & byte_ready.
//     Each transfer: word <= {word[23:0], byte_dado}; count++ (2-bit). Transfer with count==3 ->
//     ESCREVENDO. byte_valid low cycles insert no bytes and change nothing.
//   - ESCREVENDO (exactly 1 cycle): byte_ready=0; mem_we=1, mem_addr=addr, mem_wdata=assembled word;
//     palavras++ (saturates at 255). Write strobe appears the cycle after the 4th byte transfer.
//     Next: word[31:27]==HALT_OPCODE -> CONCLUIDO (HALT takes precedence even at LAST_ADDR);
//     else addr==LAST_ADDR -> ERRO; else addr++, count=0, -> RECEBENDO.
//   - CONCLUIDO: concluido=1, byte_ready=0, mem_we=0; holds until iniciar or reset.
//   - ERRO: erro=1, byte_ready=0, mem_we=0; holds until iniciar or reset. Further bytes not accepted.
//   - mem_addr/mem_wdata hold last written values outside ESCREVENDO; only mem_we qualifies them.
//   - concluido and erro are never 1 simultaneously.
// STRUCTURE
//   - Shared package: state enum (OCIOSO..ERRO), OPCODE field position [31:27], HALT opcode constant
//     (shared with the instruction decoder), instruction width 32.
//   - One sub-module natural: montador_palavra (byte counter + 32-bit shift register, outputs
//     palavra and palavra_pronta); FSM and address counter stay in the top.
// TESTING
//   - iniciar; bytes 98 00 00 00 | 0A 20 C0 00 | 90 00 00 00 -> writes addr1=98000000, addr2=0A20C000,
//     addr3=90000000 (opcode 18); concluido=1, palavras=3, byte_ready=0.
//   - Same stream with byte_valid low 3 cycles between every byte -> identical writes; mem_we pulses
//     exactly 3 times, each one cycle after 4th byte.
//   - LAST_ADDR=3, four non-HALT words (opcode 1) -> writes addr1..3 only, erro=1, 4th word never accepted
//     beyond ready=0; HALT as 3rd word instead -> concluido=1, erro=0.
//   - Reset low after 2 bytes of word 2 -> all outputs 0 immediately; iniciar + full stream reloads
//     from addr1, no stale bytes in words.
//   - iniciar pulsed mid-word in RECEBENDO -> ignored, load continues; iniciar in CONCLUIDO -> flags
//     clear, palavras=0, next write at BASE_ADDR.

Source files
------------

// File: rtl/carregador_instrucoes_pkg.sv
// Shared definitions for the instruction loader and the instruction decoder:
// loader FSM states, instruction width, opcode field position and the HALT opcode.
package carregador_instrucoes_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OPCODE_HALT = 5'd18;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    RECEBENDO  = 3'd1,
    ESCREVENDO = 3'd2,
    CONCLUIDO  = 3'd3,
    ERRO       = 3'd4
  } estado_t;

  function automatic logic [OPCODE_W-1:0] opcode_de(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [7:0] incr_saturado(input logic [7:0] valor);
    if (valor == 8'hFF) begin
      return valor;
    end else begin
      return valor + 8'd1;
    end
  endfunction

endpackage

// File: rtl/carregador_instrucoes_montador.sv
// Byte-to-word assembler: shifts bytes in MSB-first and flags the transfer
// that completes a 32-bit word (palavra is the complete word on that cycle).
module montador_palavra
  import carregador_instrucoes_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               limpar,
  input  logic               aceitar,
  input  logic [7:0]         byte_dado,
  output logic [INSTR_W-1:0] palavra,
  output logic               palavra_pronta
);

  logic [1:0]         contagem_r;
  logic [INSTR_W-1:0] registro_r;

  // The completed word is visible combinationally on the 4th transfer so the
  // write can be registered on that same edge.
  assign palavra        = {registro_r[INSTR_W-9:0], byte_dado};
  assign palavra_pronta = aceitar & (contagem_r == 2'd3);

  // Byte counter and shift register; the counter wraps to 0 after each word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_r <= 2'd0;
      registro_r <= {INSTR_W{1'b0}};
    end else if (limpar) begin
      contagem_r <= 2'd0;
      registro_r <= {INSTR_W{1'b0}};
    end else if (aceitar) begin
      contagem_r <= contagem_r + 2'd1;
      registro_r <= palavra;
    end
  end

endmodule

// File: rtl/carregador_instrucoes.sv
// Boot loader: receives the program as a byte stream, assembles big-endian words
// and writes them sequentially into the instruction store until HALT or window full.
module carregador_instrucoes
  import carregador_instrucoes_pkg::*;
#(
  parameter logic [31:0]         BASE_ADDR   = 32'd1,
  parameter logic [31:0]         LAST_ADDR   = 32'd150,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = OPCODE_HALT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        byte_valid,
  input  logic [7:0]  byte_dado,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  palavras,
  output logic        concluido,
  output logic        erro
);

  estado_t            estado_r;
  estado_t            estado_next_s;
  logic               iniciar_carga_s;
  logic               transferencia_s;
  logic               palavra_pronta_s;
  logic [INSTR_W-1:0] palavra_s;
  logic [31:0]        addr_r;
  logic               byte_ready_r;
  logic               mem_we_r;
  logic [31:0]        mem_addr_r;
  logic [31:0]        mem_wdata_r;
  logic [7:0]         palavras_r;
  logic               concluido_r;
  logic               erro_r;

  assign transferencia_s = byte_valid & byte_ready_r;

  montador_palavra u_montador (
    .clock          (clock),
    .reset          (reset),
    .limpar         (iniciar_carga_s),
    .aceitar        (transferencia_s),
    .byte_dado      (byte_dado),
    .palavra        (palavra_s),
    .palavra_pronta (palavra_pronta_s)
  );

  // Next-state logic; HALT is checked before the window limit so a HALT at the
  // last address still completes the load.
  always_comb begin
    estado_next_s   = estado_r;
    iniciar_carga_s = 1'b0;
    case (estado_r)
      OCIOSO, CONCLUIDO, ERRO: begin
        if (iniciar) begin
          estado_next_s   = RECEBENDO;
          iniciar_carga_s = 1'b1;
        end else begin
          estado_next_s   = estado_r;
        end
      end
      RECEBENDO: begin
        if (palavra_pronta_s) begin
          estado_next_s = ESCREVENDO;
        end else begin
          estado_next_s = RECEBENDO;
        end
      end
      ESCREVENDO: begin
        if (opcode_de(mem_wdata_r) == HALT_OPCODE) begin
          estado_next_s = CONCLUIDO;
        end else if (addr_r == LAST_ADDR) begin
          estado_next_s = ERRO;
        end else begin
          estado_next_s = RECEBENDO;
        end
      end
      default: begin
        estado_next_s = OCIOSO;
      end
    endcase
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r     <= OCIOSO;
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      concluido_r  <= 1'b0;
      erro_r       <= 1'b0;
    end else begin
      estado_r     <= estado_next_s;
      byte_ready_r <= (estado_next_s == RECEBENDO);
      mem_we_r     <= (estado_next_s == ESCREVENDO);
      concluido_r  <= (estado_next_s == CONCLUIDO);
      erro_r       <= (estado_next_s == ERRO);
    end
  end

  // Address counter: loaded on arm, advanced after each non-final write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r <= 32'd0;
    end else if (iniciar_carga_s) begin
      addr_r <= BASE_ADDR;
    end else if ((estado_r == ESCREVENDO) && (estado_next_s == RECEBENDO)) begin
      addr_r <= addr_r + 32'd1;
    end
  end

  // Write port and word counter; address/data hold between strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      palavras_r  <= 8'd0;
    end else if (iniciar_carga_s) begin
      palavras_r  <= 8'd0;
    end else if (palavra_pronta_s) begin
      mem_addr_r  <= addr_r;
      mem_wdata_r <= palavra_s;
      palavras_r  <= incr_saturado(palavras_r);
    end
  end

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign palavras   = palavras_r;
  assign concluido  = concluido_r;
  assign erro       = erro_r;

endmodule
